// File: rtl/delay_tester_pkg.sv
// delay_tester_pkg: shared FSM encoding, framing bytes and header offsets for the delay tester.
package delay_tester_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HDR, BODY, DROP} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [3:0] ETYPE_HI = 4'd12;
  localparam logic [3:0] ETYPE_LO = 4'd13;
  localparam logic [3:0] SEQ_HI = 4'd14;
  localparam logic [3:0] SEQ_LO = 4'd15;
endpackage

// File: rtl/probe_frame_detector_sat_counter8.sv
// sat_counter8: 8-bit counter that increments on inc and holds at 8'hFF.
module sat_counter8 (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);
  always_ff @(posedge tx_clk or posedge reset)
    if (reset) count <= 8'd0;
    else if (inc && count != 8'hFF) count <= count + 8'd1;
endmodule

// File: rtl/probe_frame_detector.sv
// probe_frame_detector: parses looped-back GMII bytes and pulses frame_caught when the
// probe sequence number matches the outstanding probe.
module probe_frame_detector
  import delay_tester_pkg::*;
#(
  parameter logic [15:0] PROBE_ETYPE = 16'h88B5,
  parameter logic [3:0]  MAX_PREAMBLE = 4'd15
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        frame_sent,
  input  logic [15:0] expect_seq,
  output logic        frame_caught,
  output logic [15:0] caught_seq,
  output logic        armed,
  output logic [7:0]  drop_count
);
  state_t state;
  logic [3:0] byte_cnt, pre_cnt;
  logic [15:0] shreg, exp_seq, word;
  logic etype_ok, abort, seq_done, match, drop_inc;
  assign word = {shreg[7:0], rxd};
  assign abort = (state == PREAMBLE || state == HDR) && (!rx_dv || rx_er);
  assign seq_done = state == HDR && rx_dv && !rx_er && byte_cnt == SEQ_LO;
  // match uses the pre-update armed/exp_seq so a coincident frame_sent cannot affect it
  assign match = seq_done && armed && word == exp_seq;
  assign drop_inc = (abort && etype_ok) || (seq_done && !match);
  sat_counter8 u_drop (.tx_clk(tx_clk), .reset(reset), .inc(drop_inc), .count(drop_count));
  always_ff @(posedge tx_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      byte_cnt <= 4'd0;
      pre_cnt <= 4'd0;
      shreg <= 16'd0;
      exp_seq <= 16'd0;
      etype_ok <= 1'b0;
      frame_caught <= 1'b0;
      caught_seq <= 16'd0;
      armed <= 1'b0;
    end else begin
      frame_caught <= match;
      if (match) caught_seq <= word;
      armed <= frame_sent | (armed & ~match);
      if (frame_sent) exp_seq <= expect_seq;
      case (state)
        IDLE:
          if (rx_dv) begin
            state <= rxd == PREAMBLE_BYTE ? PREAMBLE : DROP;
            pre_cnt <= 4'd1;
          end
        PREAMBLE:
          if (abort) state <= rx_dv ? DROP : IDLE;
          else if (rxd == SFD_BYTE) begin
            state <= HDR;
            byte_cnt <= 4'd0;
            etype_ok <= 1'b0;
          end else if (rxd != PREAMBLE_BYTE || pre_cnt == MAX_PREAMBLE) state <= DROP;
          else pre_cnt <= pre_cnt + 4'd1;
        HDR:
          if (abort) begin
            state <= rx_dv ? DROP : IDLE;
            etype_ok <= 1'b0;
          end else begin
            shreg <= word;
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == ETYPE_LO) begin
              etype_ok <= word == PROBE_ETYPE;
              if (word != PROBE_ETYPE) state <= BODY;
            end
            if (seq_done) begin
              state <= BODY;
              etype_ok <= 1'b0;
            end
          end
        default: if (!rx_dv) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_probe_frame_detector.sv
// tb_probe_frame_detector: directed probe frames with hand-computed expected outputs.
module tb_probe_frame_detector;
  logic tx_clk = 1'b0, reset = 1'b1, rx_dv = 1'b0, rx_er = 1'b0, frame_sent = 1'b0;
  logic [7:0] rxd = 8'd0;
  logic [15:0] expect_seq = 16'd0;
  logic frame_caught, armed;
  logic [15:0] caught_seq;
  logic [7:0] drop_count;
  int checks = 0, errors = 0, pulses, pulse_at, tcyc;

  probe_frame_detector dut (
    .tx_clk(tx_clk), .reset(reset), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .frame_sent(frame_sent), .expect_seq(expect_seq), .frame_caught(frame_caught),
    .caught_seq(caught_seq), .armed(armed), .drop_count(drop_count)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
    tcyc++;
    if (frame_caught) begin
      pulses++;
      if (pulse_at < 0) pulse_at = tcyc;
    end
  endtask

  task automatic arm(input logic [15:0] v);
    frame_sent = 1'b1;
    expect_seq = v;
    tick();
    frame_sent = 1'b0;
  endtask

  task automatic frame(input int pre, input logic [15:0] et, input logic [15:0] sq, input int er_at,
                       input int fs_at, input logic [15:0] fs_seq, input int rst_at, input int gap);
    logic [7:0] b[$];
    for (int i = 0; i < pre; i++) b.push_back(8'h55);
    b.push_back(8'hD5);
    for (int i = 0; i < 12; i++) b.push_back(8'hA0 + 8'(i));
    b.push_back(et[15:8]);
    b.push_back(et[7:0]);
    b.push_back(sq[15:8]);
    b.push_back(sq[7:0]);
    for (int i = 0; i < 4; i++) b.push_back(8'h11 * 8'(i + 1));
    pulses = 0;
    pulse_at = -1;
    tcyc = 0;
    for (int k = 0; k < b.size(); k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_caught", frame_caught, 0);
        check("rst_seq", caught_seq, 0);
        check("rst_armed", armed, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b0;
      end
      rx_dv = 1'b1;
      rxd = b[k];
      rx_er = k == er_at;
      frame_sent = k == fs_at;
      if (k == fs_at) expect_seq = fs_seq;
      tick();
      rx_er = 1'b0;
      frame_sent = 1'b0;
    end
    rx_dv = 1'b0;
    rxd = 8'd0;
    repeat (gap) tick();
  endtask

  initial begin
    repeat (2) @(posedge tx_clk);
    #1;
    check("reset_caught", frame_caught, 0);
    check("reset_seq", caught_seq, 0);
    check("reset_armed", armed, 0);
    check("reset_drop", drop_count, 0);
    reset = 1'b0;
    tick();
    arm(16'h0001);
    check("arm_armed", armed, 1);
    frame(7, 16'h88B5, 16'h0001, -1, -1, 0, -1, 2);
    check("match_pulses", pulses, 1);
    check("match_latency", pulse_at, 24);
    check("match_seq", caught_seq, 16'h0001);
    check("match_armed", armed, 0);
    check("match_drop", drop_count, 0);
    arm(16'h0005);
    frame(7, 16'h88B5, 16'h0006, -1, -1, 0, -1, 2);
    check("mis_pulses", pulses, 0);
    check("mis_armed", armed, 1);
    check("mis_drop", drop_count, 1);
    frame(7, 16'h0800, 16'h0005, -1, -1, 0, -1, 2);
    check("ipv4_pulses", pulses, 0);
    check("ipv4_drop", drop_count, 1);
    frame(7, 16'h88B5, 16'h0005, -1, -1, 0, -1, 2);
    check("late_match_pulses", pulses, 1);
    check("late_match_armed", armed, 0);
    frame(7, 16'h88B5, 16'h0005, -1, -1, 0, -1, 2);
    check("unarmed_pulses", pulses, 0);
    check("unarmed_drop", drop_count, 2);
    arm(16'h0007);
    frame(7, 16'h88B5, 16'h0007, 22, -1, 0, -1, 2);
    check("er_pulses", pulses, 0);
    check("er_drop", drop_count, 3);
    check("er_armed", armed, 1);
    frame(16, 16'h88B5, 16'h0007, -1, -1, 0, -1, 2);
    check("longpre_pulses", pulses, 0);
    check("longpre_drop", drop_count, 3);
    frame(15, 16'h88B5, 16'h0007, -1, -1, 0, -1, 2);
    check("maxpre_pulses", pulses, 1);
    check("maxpre_latency", pulse_at, 32);
    arm(16'h0010);
    frame(7, 16'h88B5, 16'h0010, -1, -1, 0, -1, 0);
    check("b2b_first", pulses, 1);
    arm(16'h0011);
    frame(7, 16'h88B5, 16'h0011, -1, -1, 0, -1, 2);
    check("b2b_second", pulses, 1);
    check("b2b_latency", pulse_at, 24);
    check("b2b_seq", caught_seq, 16'h0011);
    arm(16'h0020);
    frame(7, 16'h88B5, 16'h0020, -1, 23, 16'h0021, -1, 2);
    check("coinc_pulses", pulses, 1);
    check("coinc_seq", caught_seq, 16'h0020);
    check("coinc_armed", armed, 1);
    frame(7, 16'h88B5, 16'h0021, -1, -1, 0, -1, 2);
    check("coinc_next_pulses", pulses, 1);
    check("coinc_next_armed", armed, 0);
    arm(16'h0030);
    frame(7, 16'h88B5, 16'h0030, -1, -1, 0, 12, 2);
    check("midrst_pulses", pulses, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_armed", armed, 0);
    arm(16'h0040);
    for (int i = 0; i < 300; i++) begin
      frame(7, 16'h88B5, 16'h0041, -1, -1, 0, -1, 1);
      if (i == 253) check("sat_254", drop_count, 8'hFE);
    end
    check("sat_final", drop_count, 8'hFF);
    check("sat_armed", armed, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/probe_frame_detector.md
# probe_frame_detector

Receive-side probe recogniser for the delay tester. Watches the looped-back GMII byte stream, recognises the team's probe frame (preamble, SFD, EtherType, 16-bit sequence number) and emits a single-cycle `frame_caught` pulse when the sequence number matches the outstanding probe. Sits between the RX byte interface and the delay timer, which consumes `frame_sent` and `frame_caught`.

## Interface
- `PROBE_ETYPE`, 16'h88B5, EtherType identifying a probe frame.
- `MAX_PREAMBLE`, 15, longest run of 0x55 bytes accepted before SFD.
- `reset`  input  1  asynchronous, active-high; all state and outputs to reset values.
- `tx_clk`  input  1  single clock; RX data is already on this domain.
- `rx_dv`  input  1  RX data valid.
- `rx_er`  input  1  RX error, meaningful only while `rx_dv`=1.
- `rxd`  input  8  RX byte.
- `frame_sent`  input  1  one-cycle pulse from the transmitter; arms the detector.
- `expect_seq`  input  16  sequence number of the outstanding probe; sampled on `frame_sent`.
- `frame_caught`  output  1  one-cycle pulse on a matching probe.
- `caught_seq`  output  16  sequence number of the last matching probe.
- `armed`  output  1  a probe is outstanding.
- `drop_count`  output  8  saturating count of rejected probe-typed or malformed frames.

## Operation
- Reset values: `frame_caught`=0, `caught_seq`=0, `armed`=0, `drop_count`=0, state IDLE, byte counter 0.
- Arming: `frame_sent`=1 sets `armed` and latches `expect_seq` into an internal register. A match clears `armed`. A `frame_sent` pulse while already armed re-latches the sequence number.
- FSM states and transitions:
  - IDLE: `rx_dv`=1 and `rxd`=0x55 → PREAMBLE. `rx_dv`=1 with any other byte → DROP.
  - PREAMBLE: 0x55 → stay and count. 0xD5 → HDR with byte counter 0. Any other byte, or more than `MAX_PREAMBLE` 0x55 bytes → DROP.
  - HDR: counts bytes 0–15. Bytes 0–11 (MACs) are ignored. Bytes 12–13 are compared big-endian against `PROBE_ETYPE`. Bytes 14–15 form the sequence number.
    - EtherType mismatch → BODY, with no count.
    - After byte 15: if armed and sequence equals the latched value → pulse and go to BODY. If the sequence mismatches, or the detector is not armed → increment `drop_count` and go to BODY.
  - BODY: wait for `rx_dv`=0 → IDLE.
  - DROP: wait for `rx_dv`=0 → IDLE.
- Abort rules:
  - `rx_dv` falling in PREAMBLE or HDR → IDLE. If the EtherType already matched, `drop_count` is incremented.
  - `rx_er`=1 with `rx_dv`=1 in PREAMBLE or HDR → DROP, with the same counting rule.
  - `rx_er` in BODY is ignored.
- `drop_count` saturates at 8'hFF and never wraps.
- `caught_seq` updates only on a match, in the same cycle `frame_caught` asserts.

## Timing
- Match latency: `frame_caught` is high for exactly one cycle, in the cycle after the edge that samples byte 15 (the sequence LSB).
- Byte 15 is the 24th `rx_dv` byte with the minimum 7-byte preamble. Total latency from the first preamble byte is 24 cycles.
- `frame_sent` and a match decision in the same cycle: the match is evaluated against the pre-update latched sequence and `armed` value. If that match succeeds, `armed` still ends up 1, because the new probe wins.
- `frame_sent` latches on the same edge it is sampled. A probe whose byte 15 arrives on the next edge can match it.
- Back-to-back frames with a 1-cycle `rx_dv` gap must both be parsed. IDLE accepts a new preamble byte on the first cycle `rx_dv` returns.
- Reset mid-frame: the FSM goes to IDLE. The remainder of the frame is not matched, because IDLE sees a non-0x55 byte and goes to DROP.

## Structure
- Shared package `delay_tester_pkg` holds:
  - the FSM state encoding (IDLE, PREAMBLE, HDR, BODY, DROP);
  - `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5;
  - header offsets (ETYPE_HI=12, ETYPE_LO=13, SEQ_HI=14, SEQ_LO=15).
- One natural sub-module: `sat_counter8`, the 8-bit saturating increment used for `drop_count`. This sub-module is reusable by the timer for overflow.
- Everything else is flat: one state register, a 4-bit byte counter, a 4-bit preamble counter, and a 16-bit shift register for EtherType and sequence.

## Test plan
- Arm, then match: pulse `frame_sent` with `expect_seq`=16'h0001, then send 7×0x55, 0xD5, 12 MAC bytes, 0x88 0xB5 0x00 0x01 and payload → `frame_caught` high for 1 cycle, 24 cycles after the first preamble byte. `caught_seq`=16'h0001, `armed`=0, `drop_count`=0.
- Sequence mismatch: arm with 16'h0005, send a probe with seq 16'h0006 → no pulse, `armed`=1, `drop_count`=1.
- Non-probe and unarmed traffic:
  - a frame with EtherType 0x0800 → no pulse, `drop_count` unchanged;
  - a correct probe while unarmed → no pulse, `drop_count`+1.
- Errors:
  - `rx_er` asserted at header byte 14 → DROP, no pulse, `drop_count`+1;
  - a 16-byte preamble → DROP.
- Saturation and gaps:
  - 300 mismatching probes → `drop_count`=8'hFF;
  - two matching probes separated by 1 idle cycle, with a re-arm between them → two pulses.
- Corners:
  - assert reset during HDR → all outputs at reset values, no pulse from the remainder of the frame;
  - `frame_sent` coincident with a matching byte 15 → pulse occurs and `armed` stays 1.
